pipe_stage_hs: RTL

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush, optional skid buffer and a stall-cycle counter. It is the generic successor to the fixed-field stage registers between pipeline stages (IF/ID … MEM/WB). The whole stage bundle is carried as one packed payload, and the stage can hold data under back-pressure without losing it or duplicating it. It sits between any two pipeline stages of the RISC-V core; the hazard unit drives `out_ready` and `flush`.

---
 rtl/pipe_stage_hs.sv | 99 +++++++++
 1 files changed

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, flush, optional two-entry
// skid buffer (registered in_ready) and a saturating stall-cycle counter.
module pipe_stage_hs #(
    parameter int DATA_W = 101,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              cnt_clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
    logic              mvld_q, mvld_d, svld_q, svld_d, rdy_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_fire, out_fire, stall;

    assign out_valid = mvld_q;
    assign out_data  = main_q;
    assign in_ready  = (SKID != 0) ? rdy_q : (~mvld_q | out_ready);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = mvld_q & out_ready;
    assign stall     = mvld_q & ~out_ready;
    assign occupancy = {1'b0, mvld_q} + {1'b0, svld_q};
    assign stall_cnt = cnt_q;

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        mvld_d = mvld_q;
        svld_d = svld_q;
        if (SKID == 0) begin
            if (in_fire) begin
                main_d = in_data;
                mvld_d = 1'b1;
            end else if (out_fire) begin
                mvld_d = 1'b0;
            end
        end else begin
            if (!mvld_q || out_fire) begin
                // Main slot frees up: the older skid beat moves first to keep FIFO order.
                if (svld_q) begin
                    main_d = skid_q;
                    mvld_d = 1'b1;
                    svld_d = in_fire;
                    if (in_fire) skid_d = in_data;
                end else begin
                    mvld_d = in_fire;
                    if (in_fire) main_d = in_data;
                end
            end else if (in_fire) begin
                skid_d = in_data;
                svld_d = 1'b1;
            end
        end
        if (flush) begin
            main_d = main_q;
            skid_d = skid_q;
            mvld_d = 1'b0;
            svld_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clear)
            cnt_d = '0;
        else if (stall && !(&cnt_q))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= '0;
            skid_q <= '0;
            mvld_q <= 1'b0;
            svld_q <= 1'b0;
            rdy_q  <= 1'b1;
            cnt_q  <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
            mvld_q <= mvld_d;
            svld_q <= svld_d;
            rdy_q  <= ~svld_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
